// File: rtl/box_finder.sv
// Raster-scans one frame for STAR_COL pixels and hands their bounding box to a box drawer.
// Optional feature macro BOX_MARGIN_EN: grow the issued box by one pixel per side, clamped.
module box_finder #(
   parameter int unsigned      xSz      = 8,
   parameter int unsigned      ySz      = 7,
   parameter int unsigned      colSz    = 3,
   parameter int unsigned      XMAX     = 159,
   parameter int unsigned      YMAX     = 119,
   parameter logic [colSz-1:0] STAR_COL = 3'b111
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [xSz-1:0]   memX,
   output logic [ySz-1:0]   memY,
   output logic             memRd,
   input  logic [colSz-1:0] memData,
   output logic [xSz-1:0]   xLeft,
   output logic [xSz-1:0]   xRight,
   output logic [ySz-1:0]   yTop,
   output logic [ySz-1:0]   yBottom,
   output logic             goDraw,
   input  logic             doneDraw,
   output logic             busy,
   output logic             found,
   output logic             doneFind
);

   localparam logic [xSz-1:0] XLast = xSz'(XMAX);
   localparam logic [ySz-1:0] YLast = ySz'(YMAX);
   localparam logic [xSz-1:0] XOne  = xSz'(1);
   localparam logic [ySz-1:0] YOne  = ySz'(1);

   typedef enum logic [2:0] {
      StIdle, StScan, StDrain, StIssue, StWaitDraw, StFinish
   } state_e;

   state_e         r_state, w_state_nxt;
   logic [xSz-1:0] r_x, r_dx, r_min_x, r_max_x, r_xl, r_xr;
   logic [ySz-1:0] r_y, r_dy, r_min_y, r_max_y, r_yt, r_yb;
   logic           r_vld, r_found;

   logic           w_start_ok, w_scan_last, w_hit, w_found_nxt;
   logic [xSz-1:0] w_min_x_nxt, w_max_x_nxt, w_xl, w_xr;
   logic [ySz-1:0] w_min_y_nxt, w_max_y_nxt, w_yt, w_yb;

   assign w_start_ok  = (r_state == StIdle) && start;
   assign w_scan_last = (r_x == XLast) && (r_y == YLast);

   // Pixel data lags the address by one cycle, so the compare uses the delayed address.
   assign w_hit       = r_vld && (memData == STAR_COL);
   assign w_found_nxt = r_found | w_hit;
   assign w_min_x_nxt = (w_hit && (r_dx < r_min_x)) ? r_dx : r_min_x;
   assign w_max_x_nxt = (w_hit && (r_dx > r_max_x)) ? r_dx : r_max_x;
   assign w_min_y_nxt = (w_hit && (r_dy < r_min_y)) ? r_dy : r_min_y;
   assign w_max_y_nxt = (w_hit && (r_dy > r_max_y)) ? r_dy : r_max_y;

   always_comb begin
`ifdef BOX_MARGIN_EN
      w_xl = (w_min_x_nxt == '0)    ? '0    : w_min_x_nxt - XOne;
      w_xr = (w_max_x_nxt == XLast) ? XLast : w_max_x_nxt + XOne;
      w_yt = (w_min_y_nxt == '0)    ? '0    : w_min_y_nxt - YOne;
      w_yb = (w_max_y_nxt == YLast) ? YLast : w_max_y_nxt + YOne;
`else
      w_xl = w_min_x_nxt;
      w_xr = w_max_x_nxt;
      w_yt = w_min_y_nxt;
      w_yb = w_max_y_nxt;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:     if (start) w_state_nxt = StScan;
         StScan:     if (w_scan_last) w_state_nxt = StDrain;
         StDrain:    w_state_nxt = w_found_nxt ? StIssue : StFinish;
         StIssue:    w_state_nxt = StWaitDraw;
         StWaitDraw: if (doneDraw) w_state_nxt = StFinish;
         StFinish:   w_state_nxt = StIdle;
         default:    w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || w_start_ok) begin
         r_x <= '0;
         r_y <= '0;
      end else if (r_state == StScan) begin
         if (r_x == XLast) begin
            r_x <= '0;
            r_y <= (r_y == YLast) ? '0 : r_y + YOne;
         end else begin
            r_x <= r_x + XOne;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld <= 1'b0;
         r_dx  <= '0;
         r_dy  <= '0;
      end else begin
         r_vld <= (r_state == StScan);
         r_dx  <= r_x;
         r_dy  <= r_y;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_start_ok) begin
         r_min_x <= XLast;
         r_max_x <= '0;
         r_min_y <= YLast;
         r_max_y <= '0;
         r_found <= 1'b0;
      end else begin
         r_min_x <= w_min_x_nxt;
         r_max_x <= w_max_x_nxt;
         r_min_y <= w_min_y_nxt;
         r_max_y <= w_max_y_nxt;
         r_found <= w_found_nxt;
      end
   end

   // Box is latched as DRAIN folds in the last pixel, so it is valid in ISSUE and held after.
   always_ff @(posedge clk) begin
      if (reset || w_start_ok) begin
         r_xl <= '0;
         r_xr <= '0;
         r_yt <= '0;
         r_yb <= '0;
      end else if ((r_state == StDrain) && w_found_nxt) begin
         r_xl <= w_xl;
         r_xr <= w_xr;
         r_yt <= w_yt;
         r_yb <= w_yb;
      end
   end

   assign memX     = r_x;
   assign memY     = r_y;
   assign memRd    = (r_state == StScan);
   assign goDraw   = (r_state == StIssue);
   assign doneFind = (r_state == StFinish);
   assign busy     = (r_state != StIdle);
   assign found    = r_found;
   assign xLeft    = r_xl;
   assign xRight   = r_xr;
   assign yTop     = r_yt;
   assign yBottom  = r_yb;

endmodule

// File: tb/tb_box_finder.sv
// Randomized self-checking bench for box_finder; expected boxes come from a frame-level model.
module tb_box_finder;

   localparam int XM        = 159;
   localparam int YM        = 119;
   localparam int W         = XM + 1;
   localparam int NPIX      = (XM + 1) * (YM + 1);
   localparam int ISSUE_CYC = NPIX + 2;

   logic       clk = 1'b0;
   logic       reset, start, doneDraw;
   logic       memRd, goDraw, busy, found, doneFind;
   logic [7:0] memX, xLeft, xRight;
   logic [6:0] memY, yTop, yBottom;
   logic [2:0] memData;

   logic [2:0] img [NPIX];
   int n_pass = 0;
   int n_chk  = 0;

   int         o_go_cnt, o_go_cyc, o_done_cnt, o_done_cyc, o_idle_cyc, o_addr_err;
   logic [29:0] o_box, o_end_box;
   logic       o_found;
   logic [49:0] o_rst_snap;

   always #5 clk = ~clk;

   box_finder dut (
      .clk(clk), .reset(reset), .start(start), .memX(memX), .memY(memY), .memRd(memRd),
      .memData(memData), .xLeft(xLeft), .xRight(xRight), .yTop(yTop), .yBottom(yBottom),
      .goDraw(goDraw), .doneDraw(doneDraw), .busy(busy), .found(found), .doneFind(doneFind)
   );

   // Image memory: one-cycle read latency; star colour on idle cycles to expose bad valid tracking.
   always @(posedge clk) memData <= memRd ? img[int'(memY) * W + int'(memX)] : 3'b111;

   function automatic logic [49:0] snap();
      return {memX, memY, memRd, goDraw, doneFind, busy, found, xLeft, xRight, yTop, yBottom};
   endfunction

   task automatic fill_img(input bit noisy);
      for (int i = 0; i < NPIX; i++) img[i] = noisy ? 3'($urandom_range(0, 6)) : 3'd0;
   endtask

   task automatic set_star(input int x, input int y);
      img[y * W + x] = 3'b111;
   endtask

   task automatic model_box(output bit f, output logic [29:0] box);
      int mnx, mxx, mny, mxy;
      mnx = XM; mxx = 0; mny = YM; mxy = 0; f = 0;
      for (int y = 0; y <= YM; y++)
         for (int x = 0; x <= XM; x++)
            if (img[y * W + x] == 3'b111) begin
               f = 1;
               if (x < mnx) mnx = x;
               if (x > mxx) mxx = x;
               if (y < mny) mny = y;
               if (y > mxy) mxy = y;
            end
      if (!f) begin
         box = '0;
      end else begin
`ifdef BOX_MARGIN_EN
         mnx = (mnx > 0) ? mnx - 1 : 0;
         mxx = (mxx < XM) ? mxx + 1 : XM;
         mny = (mny > 0) ? mny - 1 : 0;
         mxy = (mxy < YM) ? mxy + 1 : YM;
`endif
         box = {8'(mnx), 8'(mxx), 7'(mny), 7'(mxy)};
      end
   endtask

   // Starts one operation and records what the DUT does, cycle by cycle (cycle 1 = first SCAN).
   task automatic run_frame(input int lat, input bit poke, input int abort_at);
      int idx;
      o_go_cnt = 0; o_done_cnt = 0; o_addr_err = 0;
      o_go_cyc = -1; o_done_cyc = -1; o_idle_cyc = -1;
      o_box = '0; o_end_box = '0; o_found = 1'b0; o_rst_snap = '1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 1; c <= NPIX + lat + 20; c++) begin
         if (abort_at == 0 || c <= abort_at) begin
            if (c <= NPIX) begin
               idx = c - 1;
               if (memRd !== 1'b1 || memX !== 8'(idx % W) || memY !== 7'(idx / W))
                  o_addr_err++;
            end else if (c == NPIX + 1 && memRd !== 1'b0) begin
               o_addr_err++;
            end
         end
         if (goDraw === 1'b1) begin
            o_go_cnt++;
            if (o_go_cyc < 0) begin
               o_go_cyc = c;
               o_box = {xLeft, xRight, yTop, yBottom};
            end
         end
         if (doneFind === 1'b1) begin
            o_done_cnt++;
            if (o_done_cyc < 0) begin
               o_done_cyc = c;
               o_found = found;
            end
         end
         if (busy === 1'b0 && o_idle_cyc < 0) o_idle_cyc = c;
         start = 1'b0;
         doneDraw = (o_go_cyc >= 0) && (c == o_go_cyc + lat);
         if (poke) begin
            if (c <= NPIX && (c % 1000) == 500) begin
               start = 1'b1;
               doneDraw = 1'b1;
            end
            if (o_go_cyc >= 0 && c > o_go_cyc && c < o_go_cyc + lat && (c % 3) == 0) start = 1'b1;
            if (c == o_go_cyc) doneDraw = 1'b1;
         end
         if (abort_at > 0 && c == abort_at) reset = 1'b1;
         if (abort_at > 0 && c == abort_at + 1) begin
            o_rst_snap = snap();
            reset = 1'b0;
         end
         if (abort_at > 0 && c > abort_at + 60) break;
         if (o_done_cyc >= 0 && c > o_done_cyc + 2) break;
         @(negedge clk);
      end
      o_end_box = {xLeft, xRight, yTop, yBottom};
      start = 1'b0; doneDraw = 1'b0; reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; doneDraw = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (snap() !== 50'd0) $display("FAIL reset_outputs: got %h expected 0", snap());
      else n_pass++;
      n_chk++;
      if (busy !== 1'b0) $display("FAIL reset_over_start: busy got %b expected 0", busy);
      else n_pass++;
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_black_frame();
      fill_img(1'b1);
      run_frame(5, 1'b0, 0);
      n_chk++;
      if (o_found !== 1'b0) $display("FAIL black_found: got %b expected 0", o_found);
      else n_pass++;
      n_chk++;
      if (o_go_cnt != 0) $display("FAIL black_godraw: got %0d pulses expected 0", o_go_cnt);
      else n_pass++;
      n_chk++;
      if (o_done_cyc != ISSUE_CYC || o_done_cnt != 1)
         $display("FAIL black_donefind: got cycle %0d count %0d expected cycle %0d count 1",
                  o_done_cyc, o_done_cnt, ISSUE_CYC);
      else n_pass++;
      n_chk++;
      if (o_idle_cyc != ISSUE_CYC + 1)
         $display("FAIL black_busy_low: got %0d expected %0d", o_idle_cyc, ISSUE_CYC + 1);
      else n_pass++;
      n_chk++;
      if (o_addr_err != 0) $display("FAIL black_addr: got %0d bad cycles expected 0", o_addr_err);
      else n_pass++;
      n_chk++;
      if (o_end_box !== 30'd0) $display("FAIL black_box_zero: got %h expected 0", o_end_box);
      else n_pass++;
   endtask

   // Shared by the single-pixel, random and post-reset scenarios; name tags each FAIL line.
   task automatic test_box_frame(input string name, input int lat, input bit poke);
      bit          ef;
      logic [29:0] eb;
      model_box(ef, eb);
      run_frame(lat, poke, 0);
      n_chk++;
      if (o_go_cyc != ISSUE_CYC || o_go_cnt != 1)
         $display("FAIL %s_godraw: got cycle %0d count %0d expected cycle %0d count 1",
                  name, o_go_cyc, o_go_cnt, ISSUE_CYC);
      else n_pass++;
      n_chk++;
      if (o_box !== eb) $display("FAIL %s_box: got %h expected %h", name, o_box, eb);
      else n_pass++;
      n_chk++;
      if (o_done_cyc != o_go_cyc + lat + 1 || o_done_cnt != 1)
         $display("FAIL %s_donefind: got cycle %0d count %0d expected cycle %0d count 1",
                  name, o_done_cyc, o_done_cnt, o_go_cyc + lat + 1);
      else n_pass++;
      n_chk++;
      if (o_found !== ef) $display("FAIL %s_found: got %b expected %b", name, o_found, ef);
      else n_pass++;
      n_chk++;
      if (o_addr_err != 0) $display("FAIL %s_addr: got %0d bad cycles expected 0", name, o_addr_err);
      else n_pass++;
      n_chk++;
      if (o_end_box !== eb) $display("FAIL %s_box_held: got %h expected %h", name, o_end_box, eb);
      else n_pass++;
   endtask

   task automatic test_single_pixel();
      fill_img(1'b1);
      set_star(5, 7);
      test_box_frame("single", 4, 1'b1);
   endtask

   task automatic test_random_two_pixel();
      int n;
      fill_img(1'b1);
      set_star(10, 3);
      set_star(150, 100);
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) set_star($urandom_range(10, 150), $urandom_range(3, 100));
      test_box_frame("two_pixel", 37, 1'b1);
   endtask

   task automatic test_reset_mid_scan();
      fill_img(1'b1);
      set_star(0, 0);
      set_star(XM, YM);
      run_frame(5, 1'b0, 5000);
      n_chk++;
      if (o_rst_snap !== 50'd0) $display("FAIL abort_outputs: got %h expected 0", o_rst_snap);
      else n_pass++;
      n_chk++;
      if (o_idle_cyc != 5001) $display("FAIL abort_idle: got %0d expected 5001", o_idle_cyc);
      else n_pass++;
      n_chk++;
      if (o_go_cnt != 0 || o_done_cnt != 0)
         $display("FAIL abort_pulses: got godraw %0d donefind %0d expected 0 0",
                  o_go_cnt, o_done_cnt);
      else n_pass++;
      n_chk++;
      if (o_addr_err != 0) $display("FAIL abort_addr: got %0d bad cycles expected 0", o_addr_err);
      else n_pass++;
      test_box_frame("corner", $urandom_range(2, 50), 1'b0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; doneDraw = 1'b0;
      test_reset();
      test_black_frame();
      test_single_pixel();
      test_random_two_pixel();
      test_reset_mid_scan();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
